pc_fetch_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer for the LEGv8 datapath. It sits at the consuming end of the next-PC path. It holds CurrentPC, which it feeds to the next-PC logic and to instruction memory, and it fetches the instruction at CurrentPC over a request/acknowledge handshake with instruction memory. When the downstream stage signals completion, it loads the NextPC value computed by the next-PC logic.

---
 rtl/pc_fetch_unit_pkg.sv | 18 +
 rtl/pc_fetch_unit_fetch_counter.sv | 22 ++
 rtl/pc_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared fetch constants and state encoding
// Contents: FETCH_PC_WIDTH, FETCH_INSTR_WIDTH, FETCH_RESET_PC, fetch_state_e.
// These constants are shared with the next-PC logic and instruction memory.
package pc_fetch_unit_pkg;

  localparam int FETCH_PC_WIDTH    = 64;
  localparam int FETCH_INSTR_WIDTH = 32;

  localparam logic [FETCH_PC_WIDTH-1:0] FETCH_RESET_PC = 64'h0;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_fetch_counter.sv
// rtl/pc_fetch_unit_fetch_counter.sv - 32-bit wrapping completed-fetch counter
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset, clears count
//   inc_en in   increment by one on the rising edge
//   count  out  current count; wraps FFFFFFFF -> 0 silently
module fetch_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_en,
  output logic [31:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 32'd0;
    end else if (inc_en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter register and instruction-fetch sequencer
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned NextPC -> sticky Fault).
// Ports:
//   CLK          in   clock, rising edge
//   Reset        in   asynchronous active-high reset
//   NextPC       in   next PC, loaded verbatim on an accepted Advance
//   Advance      in   downstream consumed Instruction (honoured only in HOLD)
//   IMemAck      in   memory data valid (honoured only in REQ)
//   IMemData     in   instruction word from memory
//   CurrentPC    out  registered program counter
//   IMemAddr     out  memory address, combinationally CurrentPC
//   IMemReq      out  registered fetch request
//   Instruction  out  registered fetched instruction
//   InstrValid   out  Instruction holds the word at CurrentPC
//   FetchCount   out  completed-fetch counter
//   Fault        out  sticky misaligned-PC fault (0 when the check is not built)
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                    PC_WIDTH    = FETCH_PC_WIDTH,
  parameter int                    INSTR_WIDTH = FETCH_INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = FETCH_RESET_PC
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [PC_WIDTH-1:0]    NextPC,
  input  logic                   Advance,
  input  logic                   IMemAck,
  input  logic [INSTR_WIDTH-1:0] IMemData,
  output logic [PC_WIDTH-1:0]    CurrentPC,
  output logic [PC_WIDTH-1:0]    IMemAddr,
  output logic                   IMemReq,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic                   InstrValid,
  output logic [31:0]            FetchCount,
  output logic                   Fault
);

  fetch_state_e state, state_next;
  logic         req_next;
  logic         valid_next;
  logic         capture;
  logic         load_pc;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= ST_START;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_next   = IMemReq;
    valid_next = InstrValid;
    capture    = 1'b0;
    load_pc    = 1'b0;
    case (state)
      ST_START: begin
        state_next = ST_REQ;
        req_next   = 1'b1;
      end
      ST_REQ: begin
        if (IMemAck) begin
          capture    = 1'b1;
          valid_next = 1'b1;
          req_next   = 1'b0;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (Advance) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (NextPC[1:0] != 2'b00) begin
            // PC is left untouched so the faulting instruction address stays visible.
            valid_next = 1'b0;
            req_next   = 1'b0;
            state_next = ST_FAULT;
          end else begin
            load_pc    = 1'b1;
            valid_next = 1'b0;
            req_next   = 1'b1;
            state_next = ST_REQ;
          end
`else
          load_pc    = 1'b1;
          valid_next = 1'b0;
          req_next   = 1'b1;
          state_next = ST_REQ;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      ST_FAULT: begin
        req_next   = 1'b0;
        valid_next = 1'b0;
      end
`endif
      default: begin
        state_next = ST_START;
        req_next   = 1'b0;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      CurrentPC   <= RESET_PC;
      IMemReq     <= 1'b0;
      Instruction <= '0;
      InstrValid  <= 1'b0;
    end else begin
      IMemReq    <= req_next;
      InstrValid <= valid_next;
      if (capture) begin
        Instruction <= IMemData;
      end
      if (load_pc) begin
        CurrentPC <= NextPC;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      Fault <= 1'b0;
    end else if (state_next == ST_FAULT) begin
      Fault <= 1'b1;
    end
  end
`else
  assign Fault = 1'b0;
`endif

  assign IMemAddr = CurrentPC;

  fetch_counter u_fetch_counter (
    .clk    (CLK),
    .rst    (Reset),
    .inc_en (capture),
    .count  (FetchCount)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [63:0] NextPC;
  logic        Advance;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic [63:0] CurrentPC;
  logic [63:0] IMemAddr;
  logic        IMemReq;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic [31:0] FetchCount;
  logic        Fault;

  int vectors = 0;
  int miscompares = 0;

  pc_fetch_unit dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .NextPC      (NextPC),
    .Advance     (Advance),
    .IMemAck     (IMemAck),
    .IMemData    (IMemData),
    .CurrentPC   (CurrentPC),
    .IMemAddr    (IMemAddr),
    .IMemReq     (IMemReq),
    .Instruction (Instruction),
    .InstrValid  (InstrValid),
    .FetchCount  (FetchCount),
    .Fault       (Fault)
  );

  always #5 CLK = ~CLK;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; NextPC = 64'h0; Advance = 1'b0; IMemAck = 1'b0; IMemData = 32'h0;
    tick();
    vectors++; if (CurrentPC !== 64'h0) begin $display("FAIL reset_pc got %h want %h", CurrentPC, 64'h0); miscompares++; end
    vectors++; if (IMemReq !== 1'b0) begin $display("FAIL reset_req got %b want 0", IMemReq); miscompares++; end
    vectors++; if (Instruction !== 32'h0) begin $display("FAIL reset_instr got %h want 0", Instruction); miscompares++; end
    vectors++; if (InstrValid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", InstrValid); miscompares++; end
    vectors++; if (FetchCount !== 32'd0) begin $display("FAIL reset_count got %0d want 0", FetchCount); miscompares++; end
    vectors++; if (Fault !== 1'b0) begin $display("FAIL reset_fault got %b want 0", Fault); miscompares++; end
    Reset = 1'b0;
    tick();  // START -> REQ
  endtask

  task automatic test_first_fetch();
    vectors++; if (IMemReq !== 1'b1) begin $display("FAIL first_req got %b want 1", IMemReq); miscompares++; end
    vectors++; if (InstrValid !== 1'b0) begin $display("FAIL first_valid_pre got %b want 0", InstrValid); miscompares++; end
    IMemAck = 1'b1; IMemData = 32'hF84003E9;
    tick();
    IMemAck = 1'b0;
    vectors++; if (IMemAddr !== 64'h0) begin $display("FAIL first_addr got %h want 0", IMemAddr); miscompares++; end
    vectors++; if (Instruction !== 32'hF84003E9) begin $display("FAIL first_instr got %h want F84003E9", Instruction); miscompares++; end
    vectors++; if (InstrValid !== 1'b1) begin $display("FAIL first_valid got %b want 1", InstrValid); miscompares++; end
    vectors++; if (FetchCount !== 32'd1) begin $display("FAIL first_count got %0d want 1", FetchCount); miscompares++; end
    vectors++; if (IMemReq !== 1'b0) begin $display("FAIL first_req_drop got %b want 0", IMemReq); miscompares++; end
  endtask

  task automatic test_advance();
    NextPC = 64'h4; Advance = 1'b1;
    tick();
    Advance = 1'b0;
    vectors++; if (CurrentPC !== 64'h4) begin $display("FAIL adv_pc got %h want 4", CurrentPC); miscompares++; end
    vectors++; if (IMemAddr !== 64'h4) begin $display("FAIL adv_addr got %h want 4", IMemAddr); miscompares++; end
    vectors++; if (InstrValid !== 1'b0) begin $display("FAIL adv_valid got %b want 0", InstrValid); miscompares++; end
    vectors++; if (IMemReq !== 1'b1) begin $display("FAIL adv_req got %b want 1", IMemReq); miscompares++; end
    IMemAck = 1'b1; IMemData = 32'h8B020020;
    tick();
    IMemAck = 1'b0;
    vectors++; if (FetchCount !== 32'd2) begin $display("FAIL adv_count got %0d want 2", FetchCount); miscompares++; end
    vectors++; if (Instruction !== 32'h8B020020) begin $display("FAIL adv_instr got %h want 8B020020", Instruction); miscompares++; end
  endtask

  task automatic test_wait_states();
    NextPC = 64'h8; Advance = 1'b1;
    tick();
    Advance = 1'b0;
    for (int i = 0; i < 5; i++) begin
      NextPC = (i % 2 == 0) ? 64'hDEAD_BEEF_0000_1000 : 64'h0000_0000_0000_0024;
      tick();
      vectors++; if (IMemReq !== 1'b1) begin $display("FAIL wait_req[%0d] got %b want 1", i, IMemReq); miscompares++; end
      vectors++; if (CurrentPC !== 64'h8) begin $display("FAIL wait_pc[%0d] got %h want 8", i, CurrentPC); miscompares++; end
      vectors++; if (InstrValid !== 1'b0) begin $display("FAIL wait_valid[%0d] got %b want 0", i, InstrValid); miscompares++; end
    end
    IMemAck = 1'b1; IMemData = 32'hD2800001;
    tick();
    IMemAck = 1'b0;
    vectors++; if (InstrValid !== 1'b1) begin $display("FAIL wait_cap_valid got %b want 1", InstrValid); miscompares++; end
    vectors++; if (Instruction !== 32'hD2800001) begin $display("FAIL wait_cap_instr got %h want D2800001", Instruction); miscompares++; end
    vectors++; if (FetchCount !== 32'd3) begin $display("FAIL wait_count got %0d want 3", FetchCount); miscompares++; end
    vectors++; if (CurrentPC !== 64'h8) begin $display("FAIL wait_cap_pc got %h want 8", CurrentPC); miscompares++; end
  endtask

  task automatic test_ignored_inputs();
    // IMemAck in HOLD must not recapture or count.
    IMemAck = 1'b1; IMemData = 32'h12345678;
    tick(); tick();
    IMemAck = 1'b0;
    vectors++; if (Instruction !== 32'hD2800001) begin $display("FAIL ign_ack_instr got %h want D2800001", Instruction); miscompares++; end
    vectors++; if (FetchCount !== 32'd3) begin $display("FAIL ign_ack_count got %0d want 3", FetchCount); miscompares++; end
    vectors++; if (IMemReq !== 1'b0) begin $display("FAIL ign_ack_req got %b want 0", IMemReq); miscompares++; end
    NextPC = 64'hC; Advance = 1'b1;
    tick();
    // Advance held high in REQ must not move the PC again.
    NextPC = 64'h100;
    tick(); tick(); tick();
    vectors++; if (CurrentPC !== 64'hC) begin $display("FAIL ign_adv_pc got %h want C", CurrentPC); miscompares++; end
    vectors++; if (IMemReq !== 1'b1) begin $display("FAIL ign_adv_req got %b want 1", IMemReq); miscompares++; end
    Advance = 1'b0; IMemAck = 1'b1; IMemData = 32'hAA551234;
    tick();
    IMemAck = 1'b0;
    vectors++; if (FetchCount !== 32'd4) begin $display("FAIL ign_count got %0d want 4", FetchCount); miscompares++; end
    vectors++; if (Instruction !== 32'hAA551234) begin $display("FAIL ign_instr got %h want AA551234", Instruction); miscompares++; end
  endtask

  task automatic test_reset_mid_req();
    NextPC = 64'h40; Advance = 1'b1;
    tick();
    Advance = 1'b0;
    vectors++; if (CurrentPC !== 64'h40 || IMemReq !== 1'b1) begin $display("FAIL midreq_setup got pc=%h req=%b want pc=40 req=1", CurrentPC, IMemReq); miscompares++; end
    #2;
    Reset = 1'b1;
    #1;  // well before the next rising edge
    vectors++; if (CurrentPC !== 64'h0) begin $display("FAIL midreq_pc got %h want 0", CurrentPC); miscompares++; end
    vectors++; if (IMemReq !== 1'b0) begin $display("FAIL midreq_req got %b want 0", IMemReq); miscompares++; end
    vectors++; if (FetchCount !== 32'd0) begin $display("FAIL midreq_count got %0d want 0", FetchCount); miscompares++; end
    tick();
    Reset = 1'b0;
    tick();  // START -> REQ
    IMemAck = 1'b1; IMemData = 32'h91000421;
    tick();
    IMemAck = 1'b0;
    vectors++; if (InstrValid !== 1'b1 || FetchCount !== 32'd1) begin $display("FAIL midreq_refetch got valid=%b count=%0d want valid=1 count=1", InstrValid, FetchCount); miscompares++; end
  endtask

  task automatic test_misaligned();
    NextPC = 64'h6; Advance = 1'b1;
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    vectors++; if (Fault !== 1'b1) begin $display("FAIL mis_fault got %b want 1", Fault); miscompares++; end
    vectors++; if (CurrentPC !== 64'h0) begin $display("FAIL mis_pc got %h want 0", CurrentPC); miscompares++; end
    vectors++; if (InstrValid !== 1'b0) begin $display("FAIL mis_valid got %b want 0", InstrValid); miscompares++; end
    NextPC = 64'h8; IMemAck = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++; if (IMemReq !== 1'b0 || Fault !== 1'b1 || CurrentPC !== 64'h0) begin $display("FAIL mis_hold[%0d] got req=%b fault=%b pc=%h want req=0 fault=1 pc=0", i, IMemReq, Fault, CurrentPC); miscompares++; end
    end
    Advance = 1'b0; IMemAck = 1'b0;
`else
    Advance = 1'b0;
    vectors++; if (CurrentPC !== 64'h6) begin $display("FAIL mis_pc got %h want 6", CurrentPC); miscompares++; end
    vectors++; if (Fault !== 1'b0) begin $display("FAIL mis_fault got %b want 0", Fault); miscompares++; end
    vectors++; if (IMemReq !== 1'b1) begin $display("FAIL mis_req got %b want 1", IMemReq); miscompares++; end
`endif
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_advance();
    test_wait_states();
    test_ignored_inputs();
    test_reset_mid_req();
    test_misaligned();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
